// File: rtl/stall_mem_if.sv
// rtl/stall_mem_if.sv - request/stall/done bus between a pipeline stage and stall_mem
//
// Purpose: bundles the access handshake of stall_mem into one port.
// Signals:
//    rd       requester -> memory   read request (sampled while idle)
//    wr       requester -> memory   write request (sampled while idle)
//    addr     requester -> memory   16-bit byte address
//    data_in  requester -> memory   16-bit write data
//    data_out memory -> requester   16-bit registered read data
//    stall    memory -> requester   access in flight
//    done     memory -> requester   one-cycle completion pulse
//    err      memory -> requester   one-cycle illegal-request pulse
// Modports: master (requester side), slave (memory side).

interface stall_mem_if;
   logic        rd;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        stall;
   logic        done;
   logic        err;

   modport master (
      output rd,
      output wr,
      output addr,
      output data_in,
      input  data_out,
      input  stall,
      input  done,
      input  err
   );

   modport slave (
      input  rd,
      input  wr,
      input  addr,
      input  data_in,
      output data_out,
      output stall,
      output done,
      output err
   );
endinterface

// File: rtl/stall_mem.sv
// rtl/stall_mem.sv - multi-cycle word memory with request/stall/done handshake
//
// Purpose: word-organised data/instruction memory that takes LATENCY cycles
// per access. One access at a time; stall is held while it is in flight and
// done pulses for one cycle on completion. Read data is registered and held
// until the next read completes.
// Parameters:
//    LATENCY     cycles from request acceptance to done (2..15)
//    DEPTH_LOG2  log2 of the number of 16-bit words
// Ports:
//    clk  system clock, rising edge
//    rst  asynchronous active-low reset
//    bus  stall_mem_if.slave (rd, wr, addr, data_in, data_out, stall, done, err)
// Optional feature macro: STALL_MEM_ALIGN_CHECK_EN
//    When defined, an accepted access with addr[0]=1 runs the full latency,
//    then completes with done=1 and err=1 without touching the array or
//    data_out. When undefined, addr[0] is ignored.

module stall_mem #(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic       clk,
   input  logic       rst,
   stall_mem_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Elaboration-time parameter checks.
   if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
      $error("stall_mem: LATENCY must be within 2..15");
   end
   if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 15) begin : g_bad_depth
      $error("stall_mem: DEPTH_LOG2 must be within 1..15");
   end

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [3:0]              cnt_q;
   logic                    op_wr_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [15:0]             wdata_q;
   logic [15:0]             dout_q;
   logic                    done_q;
   logic                    err_q;
`ifdef STALL_MEM_ALIGN_CHECK_EN
   logic                    odd_q;
`endif

   logic [15:0]             mem [DEPTH];

   logic                    req_one;
   logic                    req_both;
   logic                    accept;
   logic                    reject;
   logic                    finish;
   logic                    bad_align;

   // Request decode; only meaningful while idle.
   always_comb begin
      req_one  = bus.rd ^ bus.wr;
      req_both = bus.rd & bus.wr;
      accept   = (state_q == IDLE) && req_one;
      reject   = (state_q == IDLE) && req_both;
      // Counter value 1 marks the final edge of an access.
      finish   = (state_q == BUSY) && (cnt_q == 4'd1);
`ifdef STALL_MEM_ALIGN_CHECK_EN
      bad_align = odd_q;
`else
      bad_align = 1'b0;
`endif
   end

   // FSM: state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (finish) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs. done/err/data_out are registered; stall decodes the state.
   always_comb begin
      bus.stall    = (state_q == BUSY);
      bus.done     = done_q;
      bus.err      = err_q;
      bus.data_out = dout_q;
   end

   // Latched request, latency counter and registered responses. Reset drops
   // any access in flight, so a pending write never reaches the array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= 4'd0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         dout_q  <= 16'h0000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef STALL_MEM_ALIGN_CHECK_EN
         odd_q   <= 1'b0;
`endif
      end else begin
         done_q <= finish;
         err_q  <= reject || (finish && bad_align);

         if (accept) begin
            cnt_q   <= 4'(LATENCY - 1);
            op_wr_q <= bus.wr;
            idx_q   <= bus.addr[DEPTH_LOG2:1];
            wdata_q <= bus.data_in;
`ifdef STALL_MEM_ALIGN_CHECK_EN
            odd_q   <= bus.addr[0];
`endif
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (finish && !op_wr_q && !bad_align) begin
            dout_q <= mem[idx_q];
         end
      end
   end

   // Array: no reset, contents survive rst.
   always_ff @(posedge clk) begin
      if (finish && op_wr_q && !bad_align) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule
